// File: rtl/edge_capture_ctrl.sv
//==============================================================================
// Module   : edge_capture_ctrl
// Brief    : Capture-window sequencer driving the edge-time logger enable.
//            The optional lock-wait timeout is enabled by EDGE_CAPTURE_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module edge_capture_ctrl #(
    parameter int SKIP_EDGES    = 64,
    parameter int CAPTURE_EDGES = 256,
    parameter int GAP_EDGES     = 16,
    parameter int NUM_WINDOWS   = 4,
    parameter int LOCK_TIMEOUT  = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               lock,
    output logic                               enable,
    output logic [$clog2(NUM_WINDOWS+1)-1:0]   window_idx,
    output logic                               busy,
    output logic                               done,
    output logic                               lock_err,
    output logic                               timeout
);

    localparam int WIDX_W = $clog2(NUM_WINDOWS + 1);
    localparam int C_MAX_A = (SKIP_EDGES > CAPTURE_EDGES) ? SKIP_EDGES : CAPTURE_EDGES;
    localparam int C_MAX_B = (C_MAX_A > GAP_EDGES) ? C_MAX_A : GAP_EDGES;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
    localparam int C_MAX   = (C_MAX_B > LOCK_TIMEOUT) ? C_MAX_B : LOCK_TIMEOUT;
`else
    localparam int C_MAX   = C_MAX_B;
`endif
    localparam int CNT_W   = $clog2(C_MAX + 1);

    localparam logic [CNT_W-1:0]  C_SKIP_LAST = CNT_W'(SKIP_EDGES);
    localparam logic [CNT_W-1:0]  C_CAP_LAST  = CNT_W'(CAPTURE_EDGES - 1);
    localparam logic [CNT_W-1:0]  C_GAP_LAST  = CNT_W'((GAP_EDGES > 0) ? GAP_EDGES - 1 : 0);
    localparam logic [WIDX_W-1:0] C_NUM_WIN   = WIDX_W'(NUM_WINDOWS);

    generate
        if (CAPTURE_EDGES < 1 || NUM_WINDOWS < 1 || SKIP_EDGES < 0 ||
            GAP_EDGES < 0 || LOCK_TIMEOUT < 1) begin : g_bad_params
            $error("edge_capture_ctrl: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOCKWAIT = 3'd1,
        S_SKIP     = 3'd2,
        S_CAPTURE  = 3'd3,
        S_GAP      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                enable_q, enable_d;
    logic [WIDX_W-1:0]   window_idx_q, window_idx_d;
    logic                lock_err_q, lock_err_d;
    logic [WIDX_W-1:0]   w_idx_inc;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
    logic                timeout_q, timeout_d;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            enable_q     <= 1'b0;
            window_idx_q <= '0;
            lock_err_q   <= 1'b0;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enable_q     <= enable_d;
            window_idx_q <= window_idx_d;
            lock_err_q   <= lock_err_d;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enable_d     = enable_q;
        window_idx_d = window_idx_q;
        lock_err_d   = lock_err_q;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        w_idx_inc    = window_idx_q + 1'b1;

        // Lock loss outranks counter completion; window_idx is kept so the
        // interrupted window reruns in full after the next SKIP.
        if ((state_q == S_SKIP || state_q == S_CAPTURE || state_q == S_GAP) && !lock) begin
            state_d    = S_LOCKWAIT;
            cnt_d      = '0;
            enable_d   = 1'b0;
            lock_err_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = lock ? S_SKIP : S_LOCKWAIT;
                        cnt_d        = '0;
                        enable_d     = 1'b0;
                        window_idx_d = '0;
                        lock_err_d   = 1'b0;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
                        timeout_d    = 1'b0;
`endif
                    end
                end
                S_LOCKWAIT: begin
                    if (lock) begin
                        state_d = S_SKIP;
                        cnt_d   = '0;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`endif
                    end
                end
                S_SKIP: begin
                    if (cnt_q == C_SKIP_LAST) begin
                        state_d  = S_CAPTURE;
                        cnt_d    = '0;
                        enable_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (cnt_q == C_CAP_LAST) begin
                        cnt_d        = '0;
                        window_idx_d = w_idx_inc;
                        if (w_idx_inc == C_NUM_WIN) begin
                            state_d  = S_DONE;
                            enable_d = 1'b0;
                        end else if (GAP_EDGES > 0) begin
                            state_d  = S_GAP;
                            enable_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == C_GAP_LAST) begin
                        state_d  = S_CAPTURE;
                        cnt_d    = '0;
                        enable_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    enable_d = 1'b0;
                end
            endcase
        end
    end

    assign enable     = enable_q;
    assign window_idx = window_idx_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign lock_err   = lock_err_q;
`ifdef EDGE_CAPTURE_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_edge_capture_ctrl.sv
//==============================================================================
// Module   : tb_edge_capture_ctrl
// Brief    : Scoreboard bench for edge_capture_ctrl (output-change events).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_edge_capture_ctrl;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start_g0 = 1'b0;
    logic       lock = 1'b1;

    logic       enable, busy, done, lock_err, timeout;
    logic [1:0] window_idx;
    logic       enable_g0, busy_g0, done_g0, lock_err_g0, timeout_g0;
    logic [1:0] window_idx_g0;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    logic [6:0] prev0, prev1;

    edge_capture_ctrl #(
        .SKIP_EDGES(4), .CAPTURE_EDGES(8), .GAP_EDGES(2), .NUM_WINDOWS(2), .LOCK_TIMEOUT(16)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .lock(lock),
        .enable(enable), .window_idx(window_idx), .busy(busy), .done(done),
        .lock_err(lock_err), .timeout(timeout)
    );

    edge_capture_ctrl #(
        .SKIP_EDGES(4), .CAPTURE_EDGES(8), .GAP_EDGES(0), .NUM_WINDOWS(2), .LOCK_TIMEOUT(16)
    ) dut_g0 (
        .clock(clock), .reset(reset), .start(start_g0), .lock(lock),
        .enable(enable_g0), .window_idx(window_idx_g0), .busy(busy_g0), .done(done_g0),
        .lock_err(lock_err_g0), .timeout(timeout_g0)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [6:0] mk(input logic en, input logic [1:0] idx, input logic b,
                                      input logic d, input logic le, input logic to);
        return {en, idx, b, d, le, to};
    endfunction

    task automatic push(input int which, input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    // Vector layout: {enable, window_idx[1:0], busy, done, lock_err, timeout}
    task automatic mon_one(input int which, input logic [6:0] cur, inout logic [6:0] prev);
        exp_t e;
        int   qs;
        qs = (which == 0) ? q0.size() : q1.size();
        if (cur !== prev) begin
            checks++;
            if (qs == 0) begin
                failures++;
                $display("FAIL out_change[%0d] cycle %0d: got %b, required no change from %b",
                         which, cyc, cur, prev);
            end else begin
                if (which == 0) e = q0.pop_front();
                else            e = q1.pop_front();
                if (e.cyc != cyc || e.v !== cur) begin
                    failures++;
                    $display("FAIL out_event[%0d]: got cycle %0d out %b, required cycle %0d out %b",
                             which, cyc, cur, e.cyc, e.v);
                end
            end
            prev = cur;
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic issue_start(input int which, output int e0);
        @(negedge clock);
        e0 = cyc + 1;
        if (which == 0) start = 1'b1;
        else            start_g0 = 1'b1;
    endtask

    task automatic release_start();
        @(negedge clock);
        start    = 1'b0;
        start_g0 = 1'b0;
    endtask

    task automatic drain(input int which, input int budget);
        int qs;
        for (int i = 0; i < budget; i++) begin
            qs = (which == 0) ? q0.size() : q1.size();
            if (qs == 0) break;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        qs = (which == 0) ? q0.size() : q1.size();
        checks++;
        if (qs != 0) begin
            failures++;
            $display("FAIL drain[%0d]: got %0d pending events, required 0", which, qs);
            if (which == 0) q0.delete();
            else            q1.delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2;
        push(0, cyc, 7'b0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic run_normal();
        int e0;
        issue_start(0, e0);
        push(0, e0,      mk(0, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 5,  mk(1, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 13, mk(0, 2'd1, 1, 0, 0, 0));
        push(0, e0 + 15, mk(1, 2'd1, 1, 0, 0, 0));
        push(0, e0 + 23, mk(0, 2'd2, 0, 1, 0, 0));
        release_start();
        // a start during CAPTURE must have no effect
        wait_cyc(e0 + 6);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain(0, 60);
    endtask

    initial begin
        int e0;

        repeat (3) @(negedge clock);
        checks++;
        if ({enable, window_idx, busy, done, lock_err, timeout} !== 7'b0) begin
            failures++;
            $display("FAIL reset_dut: got %b, required %b",
                     {enable, window_idx, busy, done, lock_err, timeout}, 7'b0);
        end
        checks++;
        if ({enable_g0, window_idx_g0, busy_g0, done_g0, lock_err_g0, timeout_g0} !== 7'b0) begin
            failures++;
            $display("FAIL reset_dut_g0: got %b, required %b",
                     {enable_g0, window_idx_g0, busy_g0, done_g0, lock_err_g0, timeout_g0}, 7'b0);
        end
        prev0 = 7'b0;
        prev1 = 7'b0;
        fork
            forever begin
                @(negedge clock);
                mon_one(0, {enable, window_idx, busy, done, lock_err, timeout}, prev0);
                mon_one(1, {enable_g0, window_idx_g0, busy_g0, done_g0, lock_err_g0, timeout_g0}, prev1);
            end
        join_none
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Two-window run with lock held
        run_normal();

        // Lock absent until 10 edges after start
        lock = 1'b0;
        issue_start(0, e0);
        push(0, e0,      mk(0, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 15, mk(1, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 23, mk(0, 2'd1, 1, 0, 0, 0));
        push(0, e0 + 25, mk(1, 2'd1, 1, 0, 0, 0));
        push(0, e0 + 33, mk(0, 2'd2, 0, 1, 0, 0));
        release_start();
        wait_cyc(e0 + 9);
        lock = 1'b1;
        drain(0, 60);

        // One-cycle lock drop in the 4th cycle of window 1
        issue_start(0, e0);
        push(0, e0,      mk(0, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 5,  mk(1, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 13, mk(0, 2'd1, 1, 0, 0, 0));
        push(0, e0 + 15, mk(1, 2'd1, 1, 0, 0, 0));
        push(0, e0 + 18, mk(0, 2'd1, 1, 0, 1, 0));
        push(0, e0 + 24, mk(1, 2'd1, 1, 0, 1, 0));
        push(0, e0 + 32, mk(0, 2'd2, 0, 1, 1, 0));
        release_start();
        wait_cyc(e0 + 17);
        lock = 1'b0;
        wait_cyc(e0 + 18);
        lock = 1'b1;
        drain(0, 60);

        // Async reset in the middle of window 0, then a clean rerun
        issue_start(0, e0);
        push(0, e0,     mk(0, 2'd0, 1, 0, 0, 0));
        push(0, e0 + 5, mk(1, 2'd0, 1, 0, 0, 0));
        release_start();
        wait_cyc(e0 + 7);
        pulse_reset();
        drain(0, 10);
        run_normal();

        // Lock never arrives
        lock = 1'b0;
        issue_start(0, e0);
        push(0, e0, mk(0, 2'd0, 1, 0, 0, 0));
`ifdef EDGE_CAPTURE_TIMEOUT_EN
        push(0, e0 + 16, mk(0, 2'd0, 0, 1, 0, 1));
        release_start();
        drain(0, 40);
`else
        release_start();
        drain(0, 10);
        repeat (1000) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL lockwait_hold: got busy=%b done=%b timeout=%b, required busy=1 done=0 timeout=0",
                     busy, done, timeout);
        end
`endif
        pulse_reset();
        lock = 1'b1;
        drain(0, 10);

        // GAP_EDGES=0 instance: back-to-back windows
        issue_start(1, e0);
        push(1, e0,      mk(0, 2'd0, 1, 0, 0, 0));
        push(1, e0 + 5,  mk(1, 2'd0, 1, 0, 0, 0));
        push(1, e0 + 13, mk(1, 2'd1, 1, 0, 0, 0));
        push(1, e0 + 21, mk(0, 2'd2, 0, 1, 0, 0));
        release_start();
        drain(1, 60);
        drain(0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
